// File: rtl/dco_track.sv
// rtl/dco_track.sv - DPLL oscillator stage: regenerates fout from fin_w half-period,
// bang-bang trimmed by one cycle per half-period toward fin_d rising edges.
module dco_track #(
   parameter int W         = 16,
   parameter int LOCK_CNT  = 8,
   parameter int PHASE_TOL = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fin_d,
   input  logic [W-1:0] fin_w,
   output logic         fout,
   output logic         locked,
   output logic [W-1:0] half_per
);

   localparam int            LW       = $clog2(LOCK_CNT + 1);
   localparam logic [W-1:0]  W_MIN    = W'(2);
   localparam logic [W-1:0]  W_MAX    = '1;
   localparam logic [W:0]    TOL      = (W+1)'(PHASE_TOL);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
   localparam logic [1:0]    ADJ_ZERO = 2'b00;
   localparam logic [1:0]    ADJ_UP   = 2'b01;
   localparam logic [1:0]    ADJ_DN   = 2'b11;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  cnt, cnt_nx;
   logic [W-1:0]  half_per_nx;
   logic [W-1:0]  eff;
   logic [1:0]    adj, adj_nx;
   logic [LW-1:0] lock_cnt, lock_cnt_nx;
   logic          fout_nx, locked_nx;
   logic          fin_d_q;
   logic          fin_w_ok, toggle, rise, in_phase;

   assign fin_w_ok = (fin_w >= W_MIN);
   assign toggle   = (cnt == half_per - W'(1));
   assign rise     = fin_d & ~fin_d_q;

   // Window is compared in W+1 bits so half_per < PHASE_TOL cannot wrap.
   assign in_phase = fout ? ({1'b0, cnt} <= TOL)
                          : ({1'b0, cnt} + TOL >= {1'b0, half_per});

   always_comb begin
      eff = fin_w;
      if (adj == ADJ_UP) begin
         eff = (fin_w == W_MAX) ? W_MAX : fin_w + W'(1);
      end else if (adj == ADJ_DN) begin
         eff = (fin_w <= W_MIN) ? W_MIN : fin_w - W'(1);
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      half_per_nx = half_per;
      adj_nx      = adj;
      lock_cnt_nx = lock_cnt;
      fout_nx     = fout;
      locked_nx   = locked;
      case (state)
         IDLE: begin
            fout_nx     = 1'b0;
            cnt_nx      = '0;
            lock_cnt_nx = '0;
            locked_nx   = 1'b0;
            half_per_nx = '0;
            adj_nx      = ADJ_ZERO;
            if (fin_w_ok) begin
               state_nx    = RUN;
               half_per_nx = fin_w;
            end
         end
         RUN: begin
            if (!fin_w_ok) begin
               state_nx    = IDLE;
               fout_nx     = 1'b0;
               cnt_nx      = '0;
               lock_cnt_nx = '0;
               locked_nx   = 1'b0;
               half_per_nx = '0;
               adj_nx      = ADJ_ZERO;
            end else begin
               if (toggle) begin
                  fout_nx     = ~fout;
                  cnt_nx      = '0;
                  half_per_nx = eff;
                  adj_nx      = ADJ_ZERO;
               end else begin
                  cnt_nx = cnt + W'(1);
               end
               // Detector result overrides the toggle's clear: it trims the next half-period.
               if (rise) begin
                  if (in_phase) begin
                     adj_nx = ADJ_ZERO;
                     if (lock_cnt != LOCK_MAX) begin
                        lock_cnt_nx = lock_cnt + LW'(1);
                     end
                     if (lock_cnt == LOCK_MAX - LW'(1)) begin
                        locked_nx = 1'b1;
                     end
                  end else begin
                     adj_nx      = fout ? ADJ_UP : ADJ_DN;
                     lock_cnt_nx = '0;
                     locked_nx   = 1'b0;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         half_per <= '0;
         adj      <= ADJ_ZERO;
         lock_cnt <= '0;
         fout     <= 1'b0;
         locked   <= 1'b0;
         fin_d_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         half_per <= half_per_nx;
         adj      <= adj_nx;
         lock_cnt <= lock_cnt_nx;
         fout     <= fout_nx;
         locked   <= locked_nx;
         fin_d_q  <= fin_d;
      end
   end

endmodule

// File: tb/tb_dco_track.sv
// tb/tb_dco_track.sv - directed self-checking bench for dco_track.
module tb_dco_track;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fin_d;
   logic [15:0] fin_w;
   logic        fout;
   logic        locked;
   logic [15:0] half_per;

   int n_vec = 0;
   int n_err = 0;

   dco_track #(.W(16), .LOCK_CNT(8), .PHASE_TOL(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fin_d    (fin_d),
      .fin_w    (fin_w),
      .fout     (fout),
      .locked   (locked),
      .half_per (half_per)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic [15:0] w);
      rst_n = 1'b0;
      fin_d = 1'b0;
      fin_w = 16'd0;
      step(2);
      rst_n = 1'b1;
      fin_w = w;
   endtask

   initial begin
      rst_n = 1'b0;
      fin_d = 1'b0;
      fin_w = 16'd0;
      step(2);
      chk("reset_fout", 32'(fout), 32'd0);
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_half_per", 32'(half_per), 32'd0);

      // free run at fin_w=5: 5 high / 5 low, first rise 5 cycles after RUN entry
      rst_n = 1'b1;
      fin_w = 16'd5;
      step(1);
      chk("entry_half_per", 32'(half_per), 32'd5);
      chk("entry_fout", 32'(fout), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         step(1);
         chk("period_fout", 32'(fout), 32'((k / 5) % 2));
      end
      chk("period_half_per", 32'(half_per), 32'd5);
      chk("period_locked", 32'(locked), 32'd0);

      // asynchronous reset while fout is high
      step(6);
      chk("pre_reset_fout", 32'(fout), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("async_fout", 32'(fout), 32'd0);
      chk("async_locked", 32'(locked), 32'd0);
      chk("async_half_per", 32'(half_per), 32'd0);
      step(1);
      rst_n = 1'b1;
      step(1);
      step(4);
      chk("restart_e4_fout", 32'(fout), 32'd0);
      step(1);
      chk("restart_e5_fout", 32'(fout), 32'd1);

      // fin_w below 2 keeps IDLE; dropping to 0 mid-RUN clears next edge
      do_reset(16'd1);
      step(4);
      chk("idle_fout", 32'(fout), 32'd0);
      chk("idle_half_per", 32'(half_per), 32'd0);
      fin_w = 16'd6;
      step(1);
      chk("w6_half_per", 32'(half_per), 32'd6);
      step(8);
      chk("w6_e8_fout", 32'(fout), 32'd1);
      fin_w = 16'd0;
      step(1);
      chk("drop_fout", 32'(fout), 32'd0);
      chk("drop_half_per", 32'(half_per), 32'd0);
      chk("drop_locked", 32'(locked), 32'd0);

      // lock on 8 aligned edges, then a leading edge breaks lock and stretches one low half
      do_reset(16'd5);
      step(1);
      for (int k = 0; k < 102; k++) begin
         case (k)
            74:  chk("lock_e74_locked", 32'(locked), 32'd0);
            75: begin
               chk("lock_e75_locked", 32'(locked), 32'd1);
               chk("lock_e75_half_per", 32'(half_per), 32'd5);
               chk("lock_e75_fout", 32'(fout), 32'd1);
            end
            88:  chk("lead_e88_locked", 32'(locked), 32'd1);
            89:  chk("lead_e89_locked", 32'(locked), 32'd0);
            90: begin
               chk("lead_e90_fout", 32'(fout), 32'd0);
               chk("lead_e90_half_per", 32'(half_per), 32'd6);
            end
            95:  chk("lead_e95_fout", 32'(fout), 32'd0);
            96: begin
               chk("lead_e96_fout", 32'(fout), 32'd1);
               chk("lead_e96_half_per", 32'(half_per), 32'd5);
            end
            100: chk("lead_e100_fout", 32'(fout), 32'd1);
            101: chk("lead_e101_fout", 32'(fout), 32'd0);
            default: ;
         endcase
         if (k <= 79) fin_d = (((k + 1) / 5) % 2) == 1;
         else         fin_d = (k >= 88);
         step(1);
      end

      // fin_w change mid half-period takes effect at the next toggle
      do_reset(16'd5);
      step(1);
      step(7);
      fin_w = 16'd7;
      step(2);
      chk("chg_e9_fout", 32'(fout), 32'd1);
      chk("chg_e9_half_per", 32'(half_per), 32'd5);
      step(1);
      chk("chg_e10_fout", 32'(fout), 32'd0);
      chk("chg_e10_half_per", 32'(half_per), 32'd7);
      step(6);
      chk("chg_e16_fout", 32'(fout), 32'd0);
      step(1);
      chk("chg_e17_fout", 32'(fout), 32'd1);

      // lagging edge pending, fin_w drops to 2: eff clamps at 2
      do_reset(16'd6);
      step(1);
      step(1);
      fin_d = 1'b1;
      step(1);
      chk("lag_locked", 32'(locked), 32'd0);
      step(1);
      fin_w = 16'd2;
      step(3);
      chk("clamp_e6_half_per", 32'(half_per), 32'd2);
      chk("clamp_e6_fout", 32'(fout), 32'd1);
      step(2);
      chk("clamp_e8_fout", 32'(fout), 32'd0);
      chk("clamp_e8_half_per", 32'(half_per), 32'd2);

      // leading edge pending, fin_w rises to max: eff saturates
      do_reset(16'd7);
      step(1);
      step(10);
      fin_d = 1'b1;
      step(2);
      fin_w = 16'hFFFF;
      step(2);
      chk("sat_half_per", 32'(half_per), 32'h0000FFFF);
      chk("sat_fout", 32'(fout), 32'd0);
      fin_w = 16'd0;
      step(1);
      chk("sat_drop_half_per", 32'(half_per), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
